tmboc_corr_acc: RTL and testbench

- Downstream consumer of the TMBOC PRN tracking generator.
- Takes the generator's 1-bit local TMBOC code and its period-start pulse, and builds early/prompt/late replicas with a code-bit delay line.
- Wipes off incoming baseband I/Q samples against each replica and integrates over one full code period (4092 chips).
- Presents the six integrated sums to the tracking-loop processor through a valid/ready dump handshake.

---
 rtl/tmboc_corr_acc_pkg.sv | 14 +
 rtl/tmboc_corr_acc_corr_arm.sv | 43 ++++
 rtl/tmboc_corr_acc.sv | 120 ++++++++++++
 tb/tb_tmboc_corr_acc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tmboc_corr_acc_pkg.sv
// rtl/tmboc_corr_acc_pkg.sv - shared widths, code length and code-bit sign helper for the TMBOC correlator
package tmboc_corr_acc_pkg;

   localparam int SAMP_WIDTH_DEF = 4;
   localparam int ACC_WIDTH_DEF  = 24;
   localparam int EL_DLY_DEF     = 2;
   localparam int CODE_LEN       = 4092;

   // Code bit 0 maps to +1, code bit 1 maps to -1.
   function automatic logic signed [1:0] code_to_sign(input logic code_bit);
      return code_bit ? -2'sd1 : 2'sd1;
   endfunction

endpackage

// File: rtl/tmboc_corr_acc_corr_arm.sv
// rtl/tmboc_corr_acc_corr_arm.sv - one replica arm: I/Q wipe-off and load/accumulate integrators
module tmboc_corr_acc_corr_arm
   import tmboc_corr_acc_pkg::*;
#(
   parameter int SAMP_WIDTH = SAMP_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                         rx_clk,
   input  logic                         rx_rst,
   input  logic                         en,
   input  logic                         load,
   input  logic                         code,
   input  logic signed [SAMP_WIDTH-1:0] samp_i,
   input  logic signed [SAMP_WIDTH-1:0] samp_q,
   output logic signed [ACC_WIDTH-1:0]  acc_i,
   output logic signed [ACC_WIDTH-1:0]  acc_q
);

   logic signed [1:0]           sgn;
   logic signed [ACC_WIDTH-1:0] ext_i;
   logic signed [ACC_WIDTH-1:0] ext_q;
   logic signed [ACC_WIDTH-1:0] prod_i;
   logic signed [ACC_WIDTH-1:0] prod_q;

   assign sgn = code_to_sign(code);

   // Negate after widening so the most negative sample flips to a positive value.
   assign ext_i  = ACC_WIDTH'(samp_i);
   assign ext_q  = ACC_WIDTH'(samp_q);
   assign prod_i = (sgn < 0) ? -ext_i : ext_i;
   assign prod_q = (sgn < 0) ? -ext_q : ext_q;

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         acc_i <= '0;
         acc_q <= '0;
      end else if (en) begin
         acc_i <= load ? prod_i : acc_i + prod_i;
         acc_q <= load ? prod_q : acc_q + prod_q;
      end
   end

endmodule

// File: rtl/tmboc_corr_acc.sv
// rtl/tmboc_corr_acc.sv - early/prompt/late TMBOC correlator with per-period dump handshake
module tmboc_corr_acc
   import tmboc_corr_acc_pkg::*;
#(
   parameter int SAMP_WIDTH = SAMP_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int EL_DLY     = EL_DLY_DEF
) (
   input  logic                         rx_clk,
   input  logic                         rx_rst,
   input  logic                         rx_en,
   input  logic signed [SAMP_WIDTH-1:0] rx_i,
   input  logic signed [SAMP_WIDTH-1:0] rx_q,
   input  logic                         rx_loc_code,
   input  logic                         rx_prn_sop,
   input  logic                         rx_dump_rdy,
   output logic                         tx_dump_valid,
   output logic signed [ACC_WIDTH-1:0]  tx_ie,
   output logic signed [ACC_WIDTH-1:0]  tx_qe,
   output logic signed [ACC_WIDTH-1:0]  tx_ip,
   output logic signed [ACC_WIDTH-1:0]  tx_qp,
   output logic signed [ACC_WIDTH-1:0]  tx_il,
   output logic signed [ACC_WIDTH-1:0]  tx_ql,
   output logic                         tx_dump_ovf
);

   localparam int TAPS = 2 * EL_DLY + 1;

   logic [TAPS-1:0] taps;
   logic [TAPS-1:1] dly_q;
   logic            primed;
   logic            capture;

   logic signed [ACC_WIDTH-1:0] acc_ie, acc_qe;
   logic signed [ACC_WIDTH-1:0] acc_ip, acc_qp;
   logic signed [ACC_WIDTH-1:0] acc_il, acc_ql;

   // Tap 0 is the live code bit; only the older taps are registered.
   assign taps = {dly_q, rx_loc_code};

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         dly_q <= '0;
      end else if (rx_en) begin
         dly_q <= taps[TAPS-2:0];
      end
   end

   tmboc_corr_acc_corr_arm #(.SAMP_WIDTH(SAMP_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_arm_e (
      .rx_clk (rx_clk),
      .rx_rst (rx_rst),
      .en     (rx_en),
      .load   (rx_prn_sop),
      .code   (taps[0]),
      .samp_i (rx_i),
      .samp_q (rx_q),
      .acc_i  (acc_ie),
      .acc_q  (acc_qe)
   );

   tmboc_corr_acc_corr_arm #(.SAMP_WIDTH(SAMP_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_arm_p (
      .rx_clk (rx_clk),
      .rx_rst (rx_rst),
      .en     (rx_en),
      .load   (rx_prn_sop),
      .code   (taps[EL_DLY]),
      .samp_i (rx_i),
      .samp_q (rx_q),
      .acc_i  (acc_ip),
      .acc_q  (acc_qp)
   );

   tmboc_corr_acc_corr_arm #(.SAMP_WIDTH(SAMP_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_arm_l (
      .rx_clk (rx_clk),
      .rx_rst (rx_rst),
      .en     (rx_en),
      .load   (rx_prn_sop),
      .code   (taps[2*EL_DLY]),
      .samp_i (rx_i),
      .samp_q (rx_q),
      .acc_i  (acc_il),
      .acc_q  (acc_ql)
   );

   // The period running when reset releases is partial, so its sums are never dumped.
   assign capture = rx_en && rx_prn_sop && primed;

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         primed        <= 1'b0;
         tx_dump_valid <= 1'b0;
         tx_dump_ovf   <= 1'b0;
         tx_ie         <= '0;
         tx_qe         <= '0;
         tx_ip         <= '0;
         tx_qp         <= '0;
         tx_il         <= '0;
         tx_ql         <= '0;
      end else begin
         if (rx_en && rx_prn_sop) begin
            primed <= 1'b1;
         end
         if (capture) begin
            tx_ie         <= acc_ie;
            tx_qe         <= acc_qe;
            tx_ip         <= acc_ip;
            tx_qp         <= acc_qp;
            tx_il         <= acc_il;
            tx_ql         <= acc_ql;
            tx_dump_valid <= 1'b1;
            if (tx_dump_valid && !rx_dump_rdy) begin
               tx_dump_ovf <= 1'b1;
            end
         end else if (tx_dump_valid && rx_dump_rdy) begin
            tx_dump_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tmboc_corr_acc.sv
// tb/tb_tmboc_corr_acc.sv - directed self-checking bench for tmboc_corr_acc
module tb_tmboc_corr_acc;

   localparam int SW = 4;
   localparam int AW = 24;
   localparam int ED = 1;

   logic                 rx_clk = 1'b0;
   logic                 rx_rst;
   logic                 rx_en;
   logic signed [SW-1:0] rx_i;
   logic signed [SW-1:0] rx_q;
   logic                 rx_loc_code;
   logic                 rx_prn_sop;
   logic                 rx_dump_rdy;
   logic                 tx_dump_valid;
   logic signed [AW-1:0] tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql;
   logic                 tx_dump_ovf;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   g        = 0;
   bit   alt      = 1'b0;
   logic cconst   = 1'b0;

   tmboc_corr_acc #(.SAMP_WIDTH(SW), .ACC_WIDTH(AW), .EL_DLY(ED)) dut (
      .rx_clk        (rx_clk),
      .rx_rst        (rx_rst),
      .rx_en         (rx_en),
      .rx_i          (rx_i),
      .rx_q          (rx_q),
      .rx_loc_code   (rx_loc_code),
      .rx_prn_sop    (rx_prn_sop),
      .rx_dump_rdy   (rx_dump_rdy),
      .tx_dump_valid (tx_dump_valid),
      .tx_ie         (tx_ie),
      .tx_qe         (tx_qe),
      .tx_ip         (tx_ip),
      .tx_qp         (tx_qp),
      .tx_il         (tx_il),
      .tx_ql         (tx_ql),
      .tx_dump_ovf   (tx_dump_ovf)
   );

   always #5 rx_clk = ~rx_clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic sop);
      rx_prn_sop  = sop;
      rx_loc_code = alt ? g[0] : cconst;
      @(posedge rx_clk);
      #1;
      g++;
   endtask

   task automatic body(input int n);
      repeat (n) step(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_rst      = 1'b1;
      rx_en       = 1'b1;
      rx_i        = 1;
      rx_q        = -1;
      rx_loc_code = 1'b0;
      rx_prn_sop  = 1'b0;
      rx_dump_rdy = 1'b1;
      #12;
      chk("rst_valid", tx_dump_valid, 0);
      chk("rst_ovf",   tx_dump_ovf,   0);
      chk("rst_ip",    tx_ip,         0);
      rx_rst = 1'b0;

      // Period A: unprimed, discarded
      step(1'b1);
      chk("a_no_valid", tx_dump_valid, 0);
      body(4091);

      // Period B start: dump of A-length constant-code period
      step(1'b1);
      chk("b_valid", tx_dump_valid, 1);
      chk("b_ip", tx_ip,  4092);
      chk("b_qp", tx_qp, -4092);
      chk("b_ie", tx_ie,  4092);
      chk("b_qe", tx_qe, -4092);
      chk("b_il", tx_il,  4092);
      chk("b_ql", tx_ql, -4092);
      body(4091);

      // Period C: alternating code, phase broken against B's trailing zeros
      alt = 1'b1;
      g   = 0;
      step(1'b1);
      chk("c_ip_prev", tx_ip, 4092);
      body(4091);

      // Period D start: dump of C
      step(1'b1);
      chk("d_valid", tx_dump_valid, 1);
      chk("d_ie", tx_ie, 0);
      chk("d_ip", tx_ip, 2);
      chk("d_il", tx_il, 2);
      chk("d_qe", tx_qe, 0);
      chk("d_qp", tx_qp, -2);
      chk("d_ql", tx_ql, -2);
      body(4091);

      // Period E: constant code 1, most negative sample; dump of D is all zero
      alt    = 1'b0;
      cconst = 1'b1;
      rx_i   = -8;
      rx_q   = 0;
      step(1'b1);
      chk("e_ie", tx_ie, 0);
      chk("e_ip", tx_ip, 0);
      chk("e_il", tx_il, 0);
      body(4091);

      // Period F: dump of E taken while consumer stalled, no prior valid
      rx_dump_rdy = 1'b0;
      cconst      = 1'b0;
      rx_i        = 2;
      rx_q        = 1;
      step(1'b1);
      chk("f_valid", tx_dump_valid, 1);
      chk("f_ovf",   tx_dump_ovf,   0);
      chk("f_ie", tx_ie, 32736);
      chk("f_ip", tx_ip, 32736);
      chk("f_il", tx_il, 32720);
      chk("f_qp", tx_qp, 0);
      body(4091);

      // Period G: ready coincides with capture
      rx_dump_rdy = 1'b1;
      rx_i        = -3;
      rx_q        = 2;
      step(1'b1);
      rx_dump_rdy = 1'b0;
      chk("g_valid", tx_dump_valid, 1);
      chk("g_ovf",   tx_dump_ovf,   0);
      chk("g_ie", tx_ie, 8184);
      chk("g_ip", tx_ip, 8180);
      chk("g_il", tx_il, 8176);
      chk("g_qe", tx_qe, 4092);
      chk("g_qp", tx_qp, 4090);
      chk("g_ql", tx_ql, 4088);
      body(100);
      chk("g_hold_valid", tx_dump_valid, 1);
      chk("g_hold_ip",    tx_ip,         8180);
      body(3991);

      // Period H: second capture while unread sets overflow, newest wins
      step(1'b1);
      chk("h_valid", tx_dump_valid, 1);
      chk("h_ovf",   tx_dump_ovf,   1);
      chk("h_ie", tx_ie, -12276);
      chk("h_ip", tx_ip, -12276);
      chk("h_il", tx_il, -12276);
      chk("h_qp", tx_qp, 8184);
      rx_dump_rdy = 1'b1;
      step(1'b0);
      chk("h_read_valid", tx_dump_valid, 0);
      chk("h_read_ovf",   tx_dump_ovf,   1);
      body(20);

      // Asynchronous reset between edges
      #2;
      rx_rst = 1'b1;
      #1;
      chk("arst_valid", tx_dump_valid, 0);
      chk("arst_ovf",   tx_dump_ovf,   0);
      chk("arst_ip",    tx_ip,         0);
      chk("arst_qe",    tx_qe,         0);
      rx_rst = 1'b0;

      rx_i = 1;
      rx_q = 1;
      step(1'b1);
      chk("post_rst_no_dump", tx_dump_valid, 0);
      body(6);
      rx_en = 1'b0;
      rx_i  = 5;
      step(1'b1);
      step(1'b1);
      step(1'b0);
      rx_en = 1'b1;
      rx_i  = 1;
      chk("en_low_no_dump", tx_dump_valid, 0);
      body(3);
      step(1'b1);
      chk("short_valid", tx_dump_valid, 1);
      chk("short_ip",    tx_ip,         10);
      chk("short_qp",    tx_qp,         10);
      chk("short_il",    tx_il,         10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
